// File: rtl/mdu_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct codes,
// FSM state type, step count and an operand magnitude helper.
package MDUops;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [5:0] MDU_STEPS   = 6'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    // Two's-complement magnitude when the operation is signed, raw value otherwise.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_seq_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. Purely combinational; all state lives in mdu_seq.
module mdu_step (
    input  logic        is_div,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] acc_next
);

    logic [32:0] sum;
    logic [32:0] diff;

    always_comb begin
        sum  = {1'b0, acc[63:32]} + {1'b0, operand};
        // acc[63:31] is the remainder shifted left by one with the next dividend bit.
        diff = acc[63:31] - {1'b0, operand};
        if (is_div) begin
            if (!diff[32]) begin
                acc_next = {diff[31:0], acc[30:0], 1'b1};
            end else begin
                acc_next = {acc[62:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {sum, acc[31:1]};
            end else begin
                acc_next = {1'b0, acc[63:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_seq.sv
// Sequential MIPS-style HI/LO multiply/divide unit, 32 cycles per operation
// plus one sign-fix cycle; divide by zero completes in a single cycle.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted here
// CALC  | one radix-2 step per cycle, 32 steps
// FIX   | sign correction and HI/LO writeback (no-op after divide by zero)
module mdu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    import MDUops::*;

    mdu_state_t  state, state_next;
    logic [5:0]  cnt;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [31:0] opnd;
    logic        op_div;
    logic        neg_q;
    logic        neg_r;
    logic        dz;

    logic        f_valid;
    logic        f_div;
    logic        f_signed;
    logic        accept;
    logic        div_zero;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign f_valid  = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                      (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign f_div    = funct[1];
    assign f_signed = ~funct[0];

    mdu_step u_step (
        .is_div   (op_div),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_next)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        div_zero   = 1'b0;
        case (state)
            IDLE: begin
                if (start && f_valid && !flush) begin
                    accept     = 1'b1;
                    div_zero   = f_div && (rt_val == 32'd0);
                    state_next = div_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (cnt == MDU_STEPS - 6'd1) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        prod_fix = neg_q ? (~acc + 64'd1) : acc;
        quot_fix = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_div <= f_div;
                        neg_q  <= f_signed && (rs_val[31] ^ rt_val[31]);
                        neg_r  <= f_signed && rs_val[31];
                        acc    <= {32'd0, mag(rs_val, f_signed)};
                        opnd   <= mag(rt_val, f_signed);
                        cnt    <= '0;
                        dz     <= div_zero;
                        if (div_zero) begin
                            hi   <= rs_val;
                            lo   <= '1;
                            done <= 1'b1;
                        end
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (!flush && !dz) begin
                        if (op_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[63:32];
                            lo <= prod_fix[31:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: table of operations with hand-computed results
// plus sequences for divide-by-zero, flush, MTHI/MTLO and mid-operation reset.
module tb_mdu_seq;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        flush = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs [11];

    mdu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct  (funct),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (wdata),
        .flush  (flush),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one time unit after the edge that samples the request.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic whi, input logic wlo, input logic fl, input logic [31:0] wd);
        @(negedge clk);
        start  = 1'b1;
        funct  = f;
        rs_val = a;
        rt_val = b;
        wr_hi  = whi;
        wr_lo  = wlo;
        flush  = fl;
        wdata  = wd;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        flush = 1'b0;
    endtask

    task automatic finish_check(input string nm, input logic [31:0] ehi, input logic [31:0] elo);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 33; k++) begin
            if (!(busy === 1'b1 && done === 1'b0)) ok = 1'b0;
            step();
        end
        check({nm, "_busy_window"}, {63'd0, ok}, 64'd1);
        check({nm, "_done"}, {63'd0, done}, 64'd1);
        check({nm, "_busy_end"}, {63'd0, busy}, 64'd0);
        check({nm, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({nm, "_lo"}, {32'd0, lo}, {32'd0, elo});
        step();
        check({nm, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic ok;

        vecs[0]  = '{F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2]  = '{F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{F_DIVU,  32'd1000,      32'd7,         32'd6,         32'd142};
        vecs[5]  = '{F_MULTU, 32'd6,         32'd7,         32'd0,         32'd42};
        vecs[6]  = '{F_MULT,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0,         32'd30};
        vecs[7]  = '{F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[8]  = '{F_MULT,  32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{F_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
        vecs[10] = '{F_DIVU,  32'd5,         32'd10,        32'd5,         32'd0};

        #12;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 1'b0, 32'd0);
            finish_check($sformatf("vec%0d", i), vecs[i].ehi, vecs[i].elo);
        end
        // HI/LO now hold 5 / 0 from the last vector.

        issue(6'b100000, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0);
        check("badfunct_busy", {63'd0, busy}, 64'd0);
        step();
        check("badfunct_hi", {32'd0, hi}, 64'd5);
        check("badfunct_done", {63'd0, done}, 64'd0);

        issue(F_DIVU, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("dz_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
        check("dz_hi", {32'd0, hi}, 64'd100);
        check("dz_done", {63'd0, done}, 64'd1);
        check("dz_busy", {63'd0, busy}, 64'd1);
        step();
        check("dz_busy_after", {63'd0, busy}, 64'd0);
        check("dz_done_after", {63'd0, done}, 64'd0);

        issue(F_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
        check("dzs_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFB);
        check("dzs_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
        step();
        // HI/LO: FFFF_FFFB / FFFF_FFFF

        issue(F_DIVU, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
            step();
        end
        check("flush_quiet", {63'd0, ok}, 64'd1);
        check("flush_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFB);
        check("flush_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);

        issue(F_MULTU, 32'd6, 32'd7, 1'b0, 1'b0, 1'b1, 32'd0);
        check("idleflush_busy", {63'd0, busy}, 64'd0);
        step();
        check("idleflush_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);

        issue(F_MULTU, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        wr_hi = 1'b1;
        wdata = 32'h1234_5678;
        step();
        wr_hi = 1'b0;
        check("busy_wrhi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFB);
        repeat (40) step();
        check("busy_wr_result_hi", {32'd0, hi}, 64'd0);
        check("busy_wr_result_lo", {32'd0, lo}, 64'd15);

        @(negedge clk);
        wr_hi = 1'b1;
        wdata = 32'h1234_5678;
        step();
        wr_hi = 1'b0;
        check("idle_wrhi", {32'd0, hi}, 64'h0000_0000_1234_5678);
        check("idle_wrhi_lo", {32'd0, lo}, 64'd15);

        issue(F_MULTU, 32'd6, 32'd7, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        check("start_wrlo_drop", {32'd0, lo}, 64'd15);
        repeat (40) step();
        check("start_wrlo_lo", {32'd0, lo}, 64'd42);
        check("start_wrlo_hi", {32'd0, hi}, 64'd0);

        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (19) step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(F_MULTU, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 32'd0);
        finish_check("postrst", 32'd0, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
